// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_req_t   : commit descriptor that Mem hands to writeback with each mem_wb pulse
//   wb_state_t : writeback sequencing states
//   sext_delta : widens the signed RSP adjustment to register width
package wb_pkg;

    localparam int NREGS   = 16;
    localparam int XLEN    = 64;
    localparam int REG_W   = $clog2(NREGS);
    localparam int DELTA_W = 16;
    localparam int RSP_IDX = 4;

    typedef struct packed {
        logic               lo_en;
        logic [REG_W-1:0]   lo_reg;
        logic               hi_en;
        logic [REG_W-1:0]   hi_reg;
        logic               rsp_en;
        logic [DELTA_W-1:0] rsp_delta;
        logic [XLEN-1:0]    next_rip;
        logic               halt;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_HI   = 2'd1,
        WB_RSP  = 2'd2
    } wb_state_t;

    function automatic logic [XLEN-1:0] sext_delta(input logic [DELTA_W-1:0] d);
        return {{(XLEN-DELTA_W){d[DELTA_W-1]}}, d};
    endfunction

endpackage

// File: rtl/writeback_stage_gpr_file.sv
// Architectural GPR file: NREGS x XLEN, one write port, two combinational read
// ports with same-cycle write bypass, plus an un-bypassed RSP tap used by the
// RSP adjust (which always follows the writes it depends on by a cycle).
// Ports:
//   clk, reset_n           clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata       write port
//   raddr_a/b, rdata_a/b   decode read ports
//   rdata_rsp              current stored RSP value
module gpr_file
    import wb_pkg::*;
#(
    parameter int NREGS_P = NREGS,
    parameter int XLEN_P  = XLEN,
    parameter int AW      = $clog2(NREGS_P)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN_P-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [XLEN_P-1:0] rdata_a,
    output logic [XLEN_P-1:0] rdata_b,
    output logic [XLEN_P-1:0] rdata_rsp
);

    logic [XLEN_P-1:0] r_regs [NREGS_P];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS_P; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = (we && (waddr == raddr_a)) ? wdata : r_regs[raddr_a];
    assign rdata_b   = (we && (waddr == raddr_b)) ? wdata : r_regs[raddr_b];
    assign rdata_rsp = r_regs[RSP_IDX];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage. Commits up to three results per retiring uop (lo dest,
// hi dest, RSP adjust) through one GPR write port, one per cycle, and keeps the
// register scoreboard that decode consults.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   mem_wb, wb_req, mem_result   commit request from Mem (single-cycle pulse)
//   wb_blocked                   multi-cycle commit in progress; Mem must hold
//   rd_addr_a/b, rd_data_a/b     decode register reads (write bypassed)
//   sb_set_en, sb_set_mask       decode marks destinations pending
//   sb_pending                   scoreboard, 1 = write outstanding
//   retire_count, retired_rip    retirement counter and last retired next_rip
//   halted                       sticky halt flag
//
// state   | meaning
// WB_IDLE | ready; a mem_wb pulse writes lo and captures the rest
// WB_HI   | writing the captured hi result
// WB_RSP  | writing RSP + sign-extended delta
module writeback_stage
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_wb,
    input  wb_req_t           wb_req,
    input  logic [2*XLEN-1:0] mem_result,
    output logic              wb_blocked,
    input  logic [REG_W-1:0]  rd_addr_a,
    input  logic [REG_W-1:0]  rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              sb_set_en,
    input  logic [NREGS-1:0]  sb_set_mask,
    output logic [NREGS-1:0]  sb_pending,
    output logic [XLEN-1:0]   retire_count,
    output logic [XLEN-1:0]   retired_rip,
    output logic              halted
);

    wb_state_t          r_state;
    logic [REG_W-1:0]   r_hi_reg;
    logic [XLEN-1:0]    r_hi_data;
    logic               r_rsp_en;
    logic [DELTA_W-1:0] r_rsp_delta;
    logic [XLEN-1:0]    r_next_rip;
    logic               r_halt;
    logic [NREGS-1:0]   r_sb;
    logic [XLEN-1:0]    r_retire_count;
    logic [XLEN-1:0]    r_retired_rip;
    logic               r_halted;

    wb_state_t          w_state_nxt;
    logic               w_we;
    logic               w_we_gated;
    logic [REG_W-1:0]   w_waddr;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_rsp_val;
    logic               w_capture;
    logic               w_retire;
    logic [XLEN-1:0]    w_ret_rip;
    logic               w_ret_halt;
    logic               w_blocked;
    logic [NREGS-1:0]   w_sb_clr;
    logic [NREGS-1:0]   w_sb_set;

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = '0;
        w_wdata     = '0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        w_ret_rip   = r_next_rip;
        w_ret_halt  = r_halt;
        w_blocked   = (r_state != WB_IDLE);
        case (r_state)
            WB_IDLE: begin
                if (mem_wb && !r_halted) begin
                    w_capture = 1'b1;
                    w_we      = wb_req.lo_en;
                    w_waddr   = wb_req.lo_reg;
                    w_wdata   = mem_result[XLEN-1:0];
                    if (wb_req.hi_en) begin
                        w_state_nxt = WB_HI;
                        w_blocked   = 1'b1;
                    end else if (wb_req.rsp_en) begin
                        w_state_nxt = WB_RSP;
                        w_blocked   = 1'b1;
                    end else begin
                        // Single-cycle commit retires straight from the live request.
                        w_retire   = 1'b1;
                        w_ret_rip  = wb_req.next_rip;
                        w_ret_halt = wb_req.halt;
                    end
                end
            end
            WB_HI: begin
                w_we    = 1'b1;
                w_waddr = r_hi_reg;
                w_wdata = r_hi_data;
                if (r_rsp_en) begin
                    w_state_nxt = WB_RSP;
                end else begin
                    w_retire    = 1'b1;
                    w_state_nxt = WB_IDLE;
                end
            end
            WB_RSP: begin
                // RSP is read from the array, so any lo/hi write to RSP is already visible.
                w_we        = 1'b1;
                w_waddr     = REG_W'(RSP_IDX);
                w_wdata     = w_rsp_val + sext_delta(r_rsp_delta);
                w_retire    = 1'b1;
                w_state_nxt = WB_IDLE;
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    // A write on the reset cycle must not appear on the bypass path either.
    assign w_we_gated = w_we & reset_n;
    assign w_sb_clr   = w_we_gated ? ({{(NREGS-1){1'b0}}, 1'b1} << w_waddr) : '0;
    assign w_sb_set   = (sb_set_en && !r_halted) ? sb_set_mask : '0;

    gpr_file u_gpr_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (w_we_gated),
        .waddr     (w_waddr),
        .wdata     (w_wdata),
        .raddr_a   (rd_addr_a),
        .raddr_b   (rd_addr_b),
        .rdata_a   (rd_data_a),
        .rdata_b   (rd_data_b),
        .rdata_rsp (w_rsp_val)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= WB_IDLE;
            r_hi_reg       <= '0;
            r_hi_data      <= '0;
            r_rsp_en       <= 1'b0;
            r_rsp_delta    <= '0;
            r_next_rip     <= '0;
            r_halt         <= 1'b0;
            r_sb           <= '0;
            r_retire_count <= '0;
            r_retired_rip  <= '0;
            r_halted       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_hi_reg    <= wb_req.hi_reg;
                r_hi_data   <= mem_result[2*XLEN-1:XLEN];
                r_rsp_en    <= wb_req.rsp_en;
                r_rsp_delta <= wb_req.rsp_delta;
                r_next_rip  <= wb_req.next_rip;
                r_halt      <= wb_req.halt;
            end
            // Set after clear: a newly issued producer outranks the retiring one.
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
            if (w_retire) begin
                r_retire_count <= r_retire_count + 64'd1;
                r_retired_rip  <= w_ret_rip;
                r_halted       <= r_halted | w_ret_halt;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && (r_state != WB_IDLE)) begin
            assert (!mem_wb) else $error("mem_wb pulsed while writeback busy");
        end
    end
`endif

    assign wb_blocked   = w_blocked;
    assign sb_pending   = r_sb;
    assign retire_count = r_retire_count;
    assign retired_rip  = r_retired_rip;
    assign halted       = r_halted;

endmodule
